// File: rtl/flash_responder_if.sv
// FL_* request/status signal bundle between an initiator (master) and the
// flash responder (slave). The shared FL_DATA bus is a separate inout port on
// the responder because it is bidirectional and resolved outside this bundle.
//
// Handshake: FL_TRG is a single-cycle request strobe sampled on every rising
// edge. The responder accepts it only while FL_STATUS is low (IDLE or HOLD).
// FL_STATUS high means busy. A strobe seen while busy is dropped and recorded
// in the sticky OVERRUN flag.
interface flash_responder_if #(
  parameter int ADDR_W = 8
) ();
  logic              FL_TRG;
  logic              FL_FLOW;
  logic [ADDR_W-1:0] FL_ADDR;
  logic              FL_STATUS;
  logic              OVERRUN;
  // Debug visibility: FSM state and FL_DATA output enable.
  logic [1:0]        dbg_state;
  logic              dbg_bus_en;

  modport master (
    output FL_TRG, FL_FLOW, FL_ADDR,
    input  FL_STATUS, OVERRUN, dbg_state, dbg_bus_en
  );

  modport slave (
    input  FL_TRG, FL_FLOW, FL_ADDR,
    output FL_STATUS, OVERRUN, dbg_state, dbg_bus_en
  );
endinterface

// File: rtl/flash_responder.sv
// Target-side model of the FL_* byte-access interface. It holds a
// 2**ADDR_W x DATA_W store behind the tristate FL_DATA bus and inserts
// WAIT_CYCLES busy cycles before each access. The store is set to ERASED_VAL
// at power-up only; RST leaves its contents alone.
module flash_responder #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                WAIT_CYCLES = 4,
  parameter logic [DATA_W-1:0] ERASED_VAL  = 8'hFF
) (
  input  logic               CLK_50MHZ,
  input  logic               RST,
  flash_responder_if.slave   fl,
  inout  wire  [DATA_W-1:0]  FL_DATA
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              flow_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              status_q;
  logic              overrun_q;

  // Power-up content of the store; RST does not touch it.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: ERASED_VAL};

  logic access_now;
  logic bus_en;

  // The access edge is the BUSY edge on which the countdown has expired.
  assign access_now = (state_q == ST_BUSY) && (cnt_q == '0);

  // Read data is driven only in HOLD, and only while the initiator keeps the
  // live direction at read, so the bus is released in the turnaround cycle.
  assign bus_en = (state_q == ST_HOLD) && !flow_q && !fl.FL_FLOW;

  assign FL_DATA       = bus_en ? rdata_q : {DATA_W{1'bz}};
  assign fl.FL_STATUS  = status_q;
  assign fl.OVERRUN    = overrun_q;
  assign fl.dbg_state  = state_q;
  assign fl.dbg_bus_en = bus_en;

  // Store write port: commits latched write data on the access edge; an
  // access aborted by RST never reaches this point.
  always_ff @(posedge CLK_50MHZ) begin
    if (!RST && access_now && flow_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Request FSM: accept in IDLE/HOLD, count down in BUSY, then access.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      flow_q    <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (fl.FL_TRG) begin
            addr_q   <= fl.FL_ADDR;
            flow_q   <= fl.FL_FLOW;
            wdata_q  <= FL_DATA;
            cnt_q    <= CNT_LOAD;
            status_q <= 1'b1;
            state_q  <= ST_BUSY;
          end else if ((state_q == ST_HOLD) && fl.FL_FLOW) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // A strobe while busy is dropped; only the sticky flag records it.
          if (fl.FL_TRG) begin
            overrun_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            status_q <= 1'b0;
            if (flow_q) begin
              state_q <= ST_IDLE;
            end else begin
              rdata_q <= mem_q[addr_q];
              state_q <= ST_HOLD;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          status_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// Bench for flash_responder: two instances (WAIT_CYCLES=4 and 0) are exercised
// with directed scenarios and randomised traffic against a byte-array model.
module tb_flash_responder;

  localparam int W0 = 4;
  localparam int W1 = 0;

  logic clk;
  logic rst;

  // Per-instance stimulus
  logic       trg  [2];
  logic       flow [2];
  logic [7:0] addr [2];
  logic [7:0] wd   [2];
  logic       drv  [2];

  wire [7:0] fl_data0;
  wire [7:0] fl_data1;

  flash_responder_if #(.ADDR_W(8)) bus0 ();
  flash_responder_if #(.ADDR_W(8)) bus1 ();

  assign bus0.FL_TRG  = trg[0];
  assign bus0.FL_FLOW = flow[0];
  assign bus0.FL_ADDR = addr[0];
  assign bus1.FL_TRG  = trg[1];
  assign bus1.FL_FLOW = flow[1];
  assign bus1.FL_ADDR = addr[1];
  assign fl_data0 = drv[0] ? wd[0] : 8'bz;
  assign fl_data1 = drv[1] ? wd[1] : 8'bz;

  flash_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W0), .ERASED_VAL(8'hFF)) dut0 (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .fl        (bus0.slave),
    .FL_DATA   (fl_data0)
  );

  flash_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W1), .ERASED_VAL(8'hFF)) dut1 (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .fl        (bus1.slave),
    .FL_DATA   (fl_data1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain byte arrays plus a sticky overrun flag
  logic [7:0] ref_mem [2][256];
  bit         ref_ovr [2];
  bit         in_hold [2];

  int vectors;
  int miscompares;
  bit run_guard;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_status(input int d);
    return (d == 0) ? bus0.FL_STATUS : bus1.FL_STATUS;
  endfunction
  function automatic logic get_ovr(input int d);
    return (d == 0) ? bus0.OVERRUN : bus1.OVERRUN;
  endfunction
  function automatic logic get_en(input int d);
    return (d == 0) ? bus0.dbg_bus_en : bus1.dbg_bus_en;
  endfunction
  function automatic logic [7:0] get_data(input int d);
    return (d == 0) ? fl_data0 : fl_data1;
  endfunction
  function automatic int wait_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  // Bus guard: read data must never be driven while direction is write or busy
  always @(negedge clk) begin
    #1;
    if (run_guard) begin
      check_eq("bus_guard0", 32'(bus0.dbg_bus_en & (bus0.FL_FLOW | bus0.FL_STATUS)), 32'd0);
      check_eq("bus_guard1", 32'(bus1.dbg_bus_en & (bus1.FL_FLOW | bus1.FL_STATUS)), 32'd0);
    end
  end

  // Driver tasks. All drive from posedge+2; outputs are sampled on negedge.
  task automatic apply_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      trg[d] = 1'b0; flow[d] = 1'b1; drv[d] = 1'b0;
      ref_ovr[d] = 1'b0; in_hold[d] = 1'b0;
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // One complete access; ovr_at>0 fires an extra strobe after that many busy cycles.
  task automatic access(input int d, input bit wr, input logic [7:0] a,
                        input logic [7:0] dat, input int ovr_at);
    int n;
    trg[d] = 1'b1; flow[d] = wr; addr[d] = a; wd[d] = dat; drv[d] = wr;
    @(posedge clk); #2;
    trg[d] = 1'b0; drv[d] = 1'b0; addr[d] = 8'($urandom); wd[d] = 8'($urandom);
    n = 0;
    forever begin
      @(negedge clk);
      if (!get_status(d)) break;
      n++;
      if (n > 40) break;
      @(posedge clk); #2;
      if (n == ovr_at) begin
        trg[d] = 1'b1; flow[d] = 1'b1; addr[d] = a ^ 8'h3C; wd[d] = ~dat; drv[d] = 1'b1;
        ref_ovr[d] = 1'b1;
      end else begin
        trg[d] = 1'b0; flow[d] = wr; drv[d] = 1'b0;
      end
    end
    check_eq("stat_len", 32'(n), 32'(wait_of(d) + 1));
    check_eq("overrun", 32'(get_ovr(d)), 32'(ref_ovr[d]));
    if (wr) begin
      ref_mem[d][a] = dat;
      check_eq("wr_bus_idle", 32'(get_en(d)), 32'd0);
      in_hold[d] = 1'b0;
    end else begin
      check_eq("rd_bus_en", 32'(get_en(d)), 32'd1);
      check_eq("rd_data", 32'(get_data(d)), 32'(ref_mem[d][a]));
      in_hold[d] = 1'b1;
    end
    @(posedge clk); #2;
  endtask

  // Initiator turns the bus around: release must be immediate, then IDLE.
  task automatic release_bus(input int d);
    flow[d] = 1'b1;
    #1;
    check_eq("turnaround", 32'(get_en(d)), 32'd0);
    @(posedge clk); #2;
    flow[d] = 1'b0;
    #1;
    check_eq("idle_no_drive", 32'(get_en(d)), 32'd0);
    flow[d] = 1'b1;
    in_hold[d] = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    vectors = 0; miscompares = 0; run_guard = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'hFF;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 8'h00; wd[d] = 8'h00;
    end
    apply_reset();
    repeat (2) begin @(posedge clk); #2; end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_status", 32'(get_status(d)), 32'd0);
      check_eq("rst_overrun", 32'(get_ovr(d)), 32'd0);
      check_eq("rst_bus", 32'(get_en(d)), 32'd0);
    end
    @(posedge clk); #2;
    run_guard = 1'b1;

    // Write then read back
    access(0, 1'b1, 8'h10, 8'h5A, -1);
    access(0, 1'b0, 8'h10, 8'h00, -1);
    release_bus(0);

    // Untouched location reads the erased value
    access(0, 1'b0, 8'hCC, 8'h00, -1);
    release_bus(0);

    // Strobe during busy: dropped, flagged, original access on time
    access(0, 1'b1, 8'h30, 8'h77, 2);
    access(0, 1'b0, 8'h30, 8'h00, -1);
    access(0, 1'b0, 8'h30 ^ 8'h3C, 8'h00, -1);
    release_bus(0);
    check_eq("ovr_sticky", 32'(get_ovr(0)), 32'd1);

    // Reset two cycles into a busy write aborts it
    trg[0] = 1'b1; flow[0] = 1'b1; addr[0] = 8'h20; wd[0] = 8'hA5; drv[0] = 1'b1;
    @(posedge clk); #2;
    trg[0] = 1'b0; drv[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin ref_ovr[d] = 1'b0; in_hold[d] = 1'b0; end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_status", 32'(get_status(0)), 32'd0);
    check_eq("rst_busy_ovr", 32'(get_ovr(0)), 32'd0);
    @(posedge clk); #2;
    access(0, 1'b0, 8'h20, 8'h00, -1);

    // Reset in HOLD releases the bus
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    in_hold[0] = 1'b0;
    #1;
    check_eq("rst_hold_bus", 32'(get_en(0)), 32'd0);
    flow[0] = 1'b0;
    #1;
    check_eq("rst_hold_bus_rd", 32'(get_en(0)), 32'd0);
    flow[0] = 1'b1;

    // Reset and strobe on the same edge: request dropped
    rst = 1'b1; trg[0] = 1'b1; flow[0] = 1'b0; addr[0] = 8'h10;
    @(posedge clk); #2;
    rst = 1'b0; trg[0] = 1'b0;
    @(negedge clk);
    check_eq("rst_trg_status", 32'(get_status(0)), 32'd0);
    @(posedge clk); #2;
    @(negedge clk);
    check_eq("rst_trg_status2", 32'(get_status(0)), 32'd0);
    check_eq("rst_trg_bus", 32'(get_en(0)), 32'd0);
    @(posedge clk); #2;
    flow[0] = 1'b1;

    // Zero-wait instance: back-to-back with strobes issued from HOLD
    access(1, 1'b1, 8'h05, 8'hC3, -1);
    access(1, 1'b0, 8'h05, 8'h00, -1);
    access(1, 1'b0, 8'h06, 8'h00, -1);
    access(1, 1'b1, 8'h06, 8'h3E, -1);
    access(1, 1'b0, 8'h06, 8'h00, -1);
    release_bus(1);

    // Randomised traffic on both instances
    for (int i = 0; i < 120; i++) begin
      int d;
      int ov;
      bit wr;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      ov = -1;
      if (d == 0 && $urandom_range(0, 7) == 0) ov = int'($urandom_range(1, W0 - 1));
      access(d, wr, 8'h40 + 8'($urandom_range(0, 15)), 8'($urandom), ov);
      if (in_hold[d] && $urandom_range(0, 1) == 1) release_bus(d);
    end
    for (int d = 0; d < 2; d++) if (in_hold[d]) release_bus(d);

    run_guard = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
